// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 unit arbiter slice:
// FSM state encoding, FP16 field widths, op-code width and canonical qNaN.
package fp16_pkg;

    localparam int OP_W  = 2;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [FP_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_unit_arbiter_if.sv
// Bundle of requester, unit and response handshakes around the arbiter.
// slave: arbiter side; master: requesters + FP16 unit side.
interface fp16_unit_arbiter_if;
    import fp16_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op;
    logic [FP_W-1:0] req0_a;
    logic [FP_W-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op;
    logic [FP_W-1:0] req1_a;
    logic [FP_W-1:0] req1_b;

    logic            unit_valid;
    logic            unit_ready;
    logic [OP_W-1:0] unit_op;
    logic [FP_W-1:0] unit_a;
    logic [FP_W-1:0] unit_b;
    logic            unit_res_valid;
    logic [FP_W-1:0] unit_res;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [FP_W-1:0] rsp0_data;
    logic            rsp0_err;

    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [FP_W-1:0] rsp1_data;
    logic            rsp1_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output unit_valid, unit_op, unit_a, unit_b,
        input  unit_ready, unit_res_valid, unit_res,
        output rsp0_valid, rsp0_data, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data, rsp1_err,
        input  rsp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  unit_valid, unit_op, unit_a, unit_b,
        output unit_ready, unit_res_valid, unit_res,
        input  rsp0_valid, rsp0_data, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data, rsp1_err,
        output rsp1_ready
    );

endinterface

// File: rtl/fp16_rr_pick.sv
// Two-way round-robin select. A lone valid requester wins outright;
// with both valid, rr names the winner. grant is one-hot (or zero).
module fp16_rr_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       rr,
    output logic [1:0] grant,
    output logic       owner
);

    assign owner = valid1 & (~valid0 | rr);

    assign grant = {valid1 & owner, valid0 & ~owner};

endmodule

// File: rtl/fp16_unit_arbiter.sv
// Shares one FP16 unit between two requesters, one op in flight at a time,
// with a timeout that answers qNaN+err. Ports: clk, rst_n, bus (slave).
module fp16_unit_arbiter
    import fp16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst_n,
    fp16_unit_arbiter_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            rr;
    logic            owner;
    logic [CW-1:0]   cnt;
    logic [OP_W-1:0] op_q;
    logic [FP_W-1:0] a_q;
    logic [FP_W-1:0] b_q;
    logic [FP_W-1:0] data_q;
    logic            err_q;

    logic [1:0]      grant;
    logic            pick;
    logic            idle;
    logic            accept;
    logic            rsp_take;

    fp16_rr_pick u_pick (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .rr     (rr),
        .grant  (grant),
        .owner  (pick)
    );

    // rst_n gates ready so nothing is offered while reset is held
    assign idle     = (state == ST_IDLE) & rst_n;
    assign accept   = idle & (|grant);
    assign rsp_take = owner ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.req0_ready = idle & grant[0];
    assign bus.req1_ready = idle & grant[1];

    assign bus.unit_valid = (state == ST_ISSUE);
    assign bus.unit_op    = op_q;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;

    assign bus.rsp0_valid = (state == ST_RESP) & ~owner;
    assign bus.rsp1_valid = (state == ST_RESP) & owner;
    assign bus.rsp0_data  = data_q;
    assign bus.rsp1_data  = data_q;
    assign bus.rsp0_err   = err_q;
    assign bus.rsp1_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr     <= 1'b0;
            owner  <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= pick ? bus.req1_op : bus.req0_op;
                        a_q   <= pick ? bus.req1_a  : bus.req0_a;
                        b_q   <= pick ? bus.req1_b  : bus.req0_b;
                        owner <= pick;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.unit_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // a result on the terminal-count cycle beats the timeout
                    if (bus.unit_res_valid) begin
                        data_q <= bus.unit_res;
                        err_q  <= 1'b0;
                        state  <= ST_RESP;
                    end else if (cnt == LAST) begin
                        data_q <= FP16_QNAN;
                        err_q  <= 1'b1;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        rr    <= ~owner;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_unit_arbiter.sv
// Directed bench for fp16_unit_arbiter: one DUT with TIMEOUT_CYCLES=8,
// a second with TIMEOUT_CYCLES=4 for the terminal-count race.
module tb_fp16_unit_arbiter;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    fp16_unit_arbiter_if bus();
    fp16_unit_arbiter_if bus4();

    fp16_unit_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    fp16_unit_arbiter #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.unit_ready = 0; bus.unit_res_valid = 0; bus.unit_res = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        bus4.req0_valid = 0; bus4.req0_op = 0; bus4.req0_a = 0; bus4.req0_b = 0;
        bus4.req1_valid = 0; bus4.req1_op = 0; bus4.req1_a = 0; bus4.req1_b = 0;
        bus4.unit_ready = 0; bus4.unit_res_valid = 0; bus4.unit_res = 0;
        bus4.rsp0_ready = 0; bus4.rsp1_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        bus.req0_valid = 1;
        tick();
        tick();
        vecs++; if (bus.req0_ready !== 1'b0) begin errs++; $display("FAIL rst_req0_ready got %b exp 0", bus.req0_ready); end
        vecs++; if (bus.unit_valid !== 1'b0) begin errs++; $display("FAIL rst_unit_valid got %b exp 0", bus.unit_valid); end
        vecs++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b%b exp 00", bus.rsp1_valid, bus.rsp0_valid); end
        vecs++; if (bus.rsp0_data !== 16'h0000 || bus.rsp0_err !== 1'b0) begin errs++; $display("FAIL rst_rsp_data got %h/%b exp 0000/0", bus.rsp0_data, bus.rsp0_err); end
        vecs++; if (bus.unit_a !== 16'h0000 || bus.unit_op !== 2'd0) begin errs++; $display("FAIL rst_unit_bus got %h/%0d exp 0000/0", bus.unit_a, bus.unit_op); end
        bus.req0_valid = 0;
        rst_n = 1;
        #1;
        vecs++; if (bus.req0_ready !== 1'b0) begin errs++; $display("FAIL rst_idle_ready got %b exp 0", bus.req0_ready); end
    endtask

    task automatic test_single();
        bus.req0_valid = 1; bus.req0_op = 2'd1;
        bus.req0_a = 16'h3C00; bus.req0_b = 16'h4000;
        #1;
        vecs++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errs++; $display("FAIL single_ready got %b%b exp 01", bus.req1_ready, bus.req0_ready); end
        tick();
        bus.req0_valid = 0;
        vecs++; if (bus.unit_valid !== 1'b1 || bus.unit_a !== 16'h3C00 || bus.unit_b !== 16'h4000 || bus.unit_op !== 2'd1) begin errs++; $display("FAIL single_issue got %b %h %h %0d exp 1 3c00 4000 1", bus.unit_valid, bus.unit_a, bus.unit_b, bus.unit_op); end
        bus.unit_ready = 1;
        tick();
        bus.unit_ready = 0;
        vecs++; if (bus.unit_valid !== 1'b0) begin errs++; $display("FAIL single_wait_uv got %b exp 0", bus.unit_valid); end
        bus.unit_res_valid = 1; bus.unit_res = 16'h4200;
        tick();
        bus.unit_res_valid = 0;
        vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 16'h4200 || bus.rsp0_err !== 1'b0) begin errs++; $display("FAIL single_rsp got %b %h %b exp 1 4200 0", bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err); end
        vecs++; if (bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL single_rsp1 got %b exp 0", bus.rsp1_valid); end
        bus.rsp0_ready = 1;
        tick();
        bus.rsp0_ready = 0;
        vecs++; if (bus.rsp0_valid !== 1'b0) begin errs++; $display("FAIL single_done got %b exp 0", bus.rsp0_valid); end
    endtask

    task automatic test_contention();
        logic own;
        logic [15:0] exp_a;
        logic [15:0] exp_r;
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.req0_valid = 1; bus.req0_op = 2'd0; bus.req0_a = 16'h1111; bus.req0_b = 16'h0101;
        bus.req1_valid = 1; bus.req1_op = 2'd2; bus.req1_a = 16'h2222; bus.req1_b = 16'h0202;
        bus.unit_ready = 1; bus.unit_res_valid = 1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            own = i[0];
            exp_a = own ? 16'h2222 : 16'h1111;
            exp_r = 16'h5000 + 16'(i);
            bus.unit_res = exp_r;
            #1;
            vecs++; if (bus.req0_ready !== ~own || bus.req1_ready !== own) begin errs++; $display("FAIL cont_ready[%0d] got %b%b exp owner %b", i, bus.req1_ready, bus.req0_ready, own); end
            tick();
            vecs++; if (bus.unit_a !== exp_a) begin errs++; $display("FAIL cont_unit_a[%0d] got %h exp %h", i, bus.unit_a, exp_a); end
            tick();
            tick();
            vecs++; if (bus.rsp0_valid !== ~own || bus.rsp1_valid !== own) begin errs++; $display("FAIL cont_rsp_valid[%0d] got %b%b exp owner %b", i, bus.rsp1_valid, bus.rsp0_valid, own); end
            vecs++; if ((own ? bus.rsp1_data : bus.rsp0_data) !== exp_r) begin errs++; $display("FAIL cont_rsp_data[%0d] got %h exp %h", i, own ? bus.rsp1_data : bus.rsp0_data, exp_r); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        bus.req0_valid = 1; bus.req0_a = 16'hABCD; bus.req0_b = 16'h1234;
        tick();
        bus.req0_valid = 0;
        bus.unit_ready = 1;
        tick();
        bus.unit_ready = 0;
        for (int k = 0; k < 8; k++) begin
            vecs++; if (bus.rsp0_valid !== 1'b0) begin errs++; $display("FAIL tmo_early[%0d] got %b exp 0", k, bus.rsp0_valid); end
            tick();
        end
        vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 16'h7E00 || bus.rsp0_err !== 1'b1) begin errs++; $display("FAIL tmo_rsp got %b %h %b exp 1 7e00 1", bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err); end
        vecs++; if (bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL tmo_rsp1 got %b exp 0", bus.rsp1_valid); end
        bus.unit_res_valid = 1; bus.unit_res = 16'h1357;
        tick();
        vecs++; if (bus.rsp0_data !== 16'h7E00 || bus.rsp0_err !== 1'b1) begin errs++; $display("FAIL tmo_late got %h %b exp 7e00 1", bus.rsp0_data, bus.rsp0_err); end
        bus.rsp0_ready = 1;
        tick();
        bus.rsp0_ready = 0;
        tick();
        vecs++; if (bus.rsp0_valid !== 1'b0 || bus.unit_valid !== 1'b0) begin errs++; $display("FAIL tmo_idle got %b %b exp 0 0", bus.rsp0_valid, bus.unit_valid); end
        bus.unit_res_valid = 0;
    endtask

    task automatic test_back_to_back();
        bus.req1_valid = 1; bus.req1_op = 2'd3;
        bus.req1_a = 16'hBEEF; bus.req1_b = 16'hCAFE;
        tick();
        bus.req1_a = 16'h0000; bus.req1_b = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            vecs++; if (bus.unit_valid !== 1'b1 || bus.unit_a !== 16'hBEEF || bus.unit_b !== 16'hCAFE || bus.unit_op !== 2'd3) begin errs++; $display("FAIL bp_unit[%0d] got %b %h %h %0d exp 1 beef cafe 3", k, bus.unit_valid, bus.unit_a, bus.unit_b, bus.unit_op); end
            vecs++; if (bus.req1_ready !== 1'b0) begin errs++; $display("FAIL bp_accept[%0d] got %b exp 0", k, bus.req1_ready); end
            tick();
        end
        bus.unit_ready = 1;
        tick();
        bus.unit_ready = 0;
        bus.unit_res_valid = 1; bus.unit_res = 16'h3E00;
        tick();
        bus.unit_res_valid = 0;
        for (int k = 0; k < 4; k++) begin
            vecs++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 16'h3E00 || bus.rsp1_err !== 1'b0) begin errs++; $display("FAIL bp_rsp[%0d] got %b %h %b exp 1 3e00 0", k, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err); end
            vecs++; if (bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b0) begin errs++; $display("FAIL bp_other[%0d] got %b %b exp 0 0", k, bus.rsp0_valid, bus.req1_ready); end
            tick();
        end
        bus.req1_valid = 0;
        bus.rsp1_ready = 1;
        tick();
        bus.rsp1_ready = 0;
        vecs++; if (bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL bp_done got %b exp 0", bus.rsp1_valid); end
    endtask

    task automatic test_reset_in_wait();
        bus.req0_valid = 1; bus.req0_a = 16'h1111;
        tick();
        bus.req0_valid = 0;
        bus.unit_ready = 1;
        tick();
        bus.unit_ready = 0;
        tick();
        rst_n = 0;
        #1;
        vecs++; if (bus.rsp0_valid !== 1'b0 || bus.unit_valid !== 1'b0) begin errs++; $display("FAIL rw_inrst got %b %b exp 0 0", bus.rsp0_valid, bus.unit_valid); end
        tick();
        rst_n = 1;
        bus.unit_res_valid = 1; bus.unit_res = 16'hDEAD;
        tick();
        bus.unit_res_valid = 0;
        vecs++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL rw_late got %b%b exp 00", bus.rsp1_valid, bus.rsp0_valid); end
        bus.req1_valid = 1; bus.req1_a = 16'h5678; bus.req1_b = 16'h9ABC;
        #1;
        vecs++; if (bus.req1_ready !== 1'b1) begin errs++; $display("FAIL rw_req1_ready got %b exp 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 0;
        vecs++; if (bus.unit_valid !== 1'b1 || bus.unit_a !== 16'h5678) begin errs++; $display("FAIL rw_issue got %b %h exp 1 5678", bus.unit_valid, bus.unit_a); end
        bus.unit_ready = 1;
        tick();
        bus.unit_ready = 0;
        bus.unit_res_valid = 1; bus.unit_res = 16'h2468;
        tick();
        bus.unit_res_valid = 0;
        vecs++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 16'h2468) begin errs++; $display("FAIL rw_rsp got %b %h exp 1 2468", bus.rsp1_valid, bus.rsp1_data); end
        bus.rsp1_ready = 1;
        tick();
        bus.rsp1_ready = 0;
    endtask

    task automatic test_term_count();
        bus4.req0_valid = 1; bus4.req0_a = 16'h4400; bus4.req0_b = 16'h3800;
        tick();
        bus4.req0_valid = 0;
        bus4.unit_ready = 1;
        tick();
        bus4.unit_ready = 0;
        tick();
        tick();
        tick();
        vecs++; if (bus4.rsp0_valid !== 1'b0) begin errs++; $display("FAIL tc_early got %b exp 0", bus4.rsp0_valid); end
        bus4.unit_res_valid = 1; bus4.unit_res = 16'hC500;
        tick();
        bus4.unit_res_valid = 0;
        vecs++; if (bus4.rsp0_valid !== 1'b1 || bus4.rsp0_data !== 16'hC500 || bus4.rsp0_err !== 1'b0) begin errs++; $display("FAIL tc_rsp got %b %h %b exp 1 c500 0", bus4.rsp0_valid, bus4.rsp0_data, bus4.rsp0_err); end
        bus4.rsp0_ready = 1;
        tick();
        bus4.rsp0_ready = 0;
        vecs++; if (bus4.rsp0_valid !== 1'b0) begin errs++; $display("FAIL tc_done got %b exp 0", bus4.rsp0_valid); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        test_term_count();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fp16_unit_arbiter.md
FP16_UNIT_ARBITER -- requirements
Module: fp16_unit_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of cycles spent in WAIT before the arbiter aborts the op (legal range 2..255).
REQ-002 SHALL use one clock and an asynchronous active-low reset; the ports are below.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  requester N (N=0,1) has an op
- reqN_ready  out  1  arbiter accepts requester N's op
- reqN_op  in  2  op code, passed through unchanged
- reqN_a, reqN_b  in  16  FP16 operands
- unit_valid  out  1  op presented to the shared FP16 unit
- unit_ready  in  1  unit accepts the op
- unit_op  out  2; unit_a, unit_b  out  16  latched op
- unit_res_valid  in  1  unit result strobe
- unit_res  in  16  packed FP16 result {sign, exp[4:0], man[9:0]}
- rspN_valid  out  1  result available for requester N
- rspN_ready  in  1  requester N takes the result
- rspN_data  out  16  result
- rspN_err  out  1  result is a timeout abort

Function
REQ-003 SHALL share one FP16 unit between two requesters, with at most one op outstanding at any time.
REQ-004 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-005 IDLE:
- reqN_ready=1 only for the selected requester, combinationally.
- Selection: the only valid requester; if both are valid, the one indicated by round-robin pointer rr.
- On reqN_valid&reqN_ready: latch op, a, b; owner=N; go to ISSUE.
REQ-006 ISSUE:
- unit_valid=1 with the latched op, a, b held stable.
- On unit_ready: clear timeout counter; go to WAIT.
REQ-007 WAIT:
- On unit_res_valid: latch unit_res; err=0; go to RESP.
- Otherwise counter+1.
- When counter==TIMEOUT_CYCLES-1 with no result: data=16'h7E00 (qNaN); err=1; go to RESP.
REQ-008 WAIT, simultaneous events: if unit_res_valid arrives on the terminal count cycle, the result SHALL win (err=0).
REQ-009 RESP:
- rsp<owner>_valid=1 with data and err held stable.
- The other rsp_valid=0.
- On rsp<owner>_ready: rr=~owner; go to IDLE.
REQ-010 Outside IDLE, both reqN_ready SHALL be 0.
REQ-011 Outside ISSUE, unit_valid SHALL be 0.
REQ-012 unit_res_valid SHALL be ignored outside WAIT, including a late result after a timeout.
REQ-013 Timing:
- Minimum accept-to-response latency: 3 cycles (IDLE->ISSUE->WAIT->RESP), with unit_ready and unit_res_valid each asserted immediately.
- No bubble in IDLE when a requester is waiting.
REQ-014 Operand and result bits SHALL pass through unmodified; the arbiter performs no FP arithmetic.
REQ-015 The counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL never wrap past TIMEOUT_CYCLES-1.

Reset
REQ-016 On rst_n=0, asynchronously:
- state=IDLE, rr=0, owner=0, counter=0.
- Latched op/a/b/data=0, err=0.
- All valid and ready outputs=0.
REQ-017 Reset asserted mid-operation SHALL abandon the op with no response; after release, a late unit_res_valid SHALL be ignored (arbiter is in IDLE).
REQ-018 The first cycle after release SHALL behave as IDLE, with requester 0 preferred.

Structure
REQ-019 A shared package fp16_pkg SHALL hold:
- FSM state enum.
- FP16_QNAN=16'h7E00.
- FP16 field widths (EXP_W=5, MAN_W=10).
- Op-code width.
REQ-020 A sub-module fp16_rr_pick (2-way round-robin select: valid0, valid1, rr -> grant, owner) is natural; everything else SHALL reside in fp16_unit_arbiter.

Verification
REQ-021 A bench SHALL cover these scenarios:
- Single op: req0 a=16'h3C00, b=16'h4000; unit returns 16'h4200 one cycle later -> rsp0_valid with rsp0_data=16'h4200, rsp0_err=0, rsp1_valid=0.
- Contention: req0 and req1 held valid from reset -> order req0, req1, req0, req1; each response goes to the correct port.
- Timeout: TIMEOUT_CYCLES=8, unit never answers -> rsp0_data=16'h7E00, rsp0_err=1 exactly 8 cycles after entering WAIT; a late unit_res_valid is ignored.
- Backpressure: unit_ready low 5 cycles, rsp1_ready low 4 cycles -> unit_* and rsp1_* stable throughout; no second accept.
- Reset in WAIT: rst_n low for 1 cycle, then unit_res_valid -> no rsp_valid; next req1 accepted in IDLE.
- Result on terminal count: TIMEOUT_CYCLES=4, unit_res_valid in 4th WAIT cycle, data=16'hC500 -> rsp_data=16'hC500, rsp_err=0.
